// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of a single-port synchronous instruction
// memory between core fetch and a debug/loader port, with halt and contention count.
module imem_arbiter #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    input  logic                  halt,
    output logic                  halted,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  contention_cnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_q
);
    typedef enum logic {
        WIN_FETCH,
        WIN_DBG
    } win_e;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_FETCH,
        RD_DBG
    } rd_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    win_e                  last_q, last_d;
    rd_e                   rd_q, rd_d;
    logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  halted_q, halted_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  fetch_elig;
    logic                  dbg_elig;
    logic                  tie;

    // Grants are forced low while reset is asserted so memory never sees a write.
    always_comb begin
        fetch_elig = fetch_req & ~halt;
        dbg_elig   = dbg_req;
        tie        = fetch_elig & dbg_elig;
        fetch_gnt  = 1'b0;
        dbg_gnt    = 1'b0;
        if (rst_n) begin
            if (tie) begin
                fetch_gnt = (last_q == WIN_DBG);
                dbg_gnt   = (last_q == WIN_FETCH);
            end else begin
                fetch_gnt = fetch_elig;
                dbg_gnt   = dbg_elig;
            end
        end
    end

    always_comb begin
        mem_addr  = dbg_gnt ? dbg_addr : fetch_addr;
        mem_we    = dbg_gnt & dbg_we;
        mem_wdata = dbg_wdata;
    end

    always_comb begin
        last_d    = last_q;
        rd_d      = RD_NONE;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        cnt_d     = cnt_q;
        halted_d  = halt & ~fetch_gnt;
        if (fetch_gnt) begin
            last_d = WIN_FETCH;
            rd_d   = RD_FETCH;
        end else if (dbg_gnt) begin
            last_d = WIN_DBG;
            rd_d   = dbg_we ? RD_NONE : RD_DBG;
        end
        if (rd_q == RD_FETCH) begin
            f_rdata_d = mem_q;
        end
        if (rd_q == RD_DBG) begin
            d_rdata_d = mem_q;
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (tie && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= WIN_DBG;
            rd_q      <= RD_NONE;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            last_q    <= last_d;
            rd_q      <= rd_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
            halted_q  <= halted_d;
            cnt_q     <= cnt_d;
        end
    end

    // Read data is passed straight from memory in the return cycle, then held.
    assign fetch_rvalid   = (rd_q == RD_FETCH);
    assign dbg_rvalid     = (rd_q == RD_DBG);
    assign fetch_rdata    = fetch_rvalid ? mem_q : f_rdata_q;
    assign dbg_rdata      = dbg_rvalid ? mem_q : d_rdata_q;
    assign halted         = halted_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model of the arbiter and memory.
module tb_imem_arbiter;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_gnt;
    logic          fetch_rvalid;
    logic [DW-1:0] fetch_rdata;
    logic          dbg_req = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          halt = 1'b0;
    logic          halted;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] contention_cnt;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_q = '0;

    int checks = 0;
    int errors = 0;

    imem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
        .fetch_rdata(fetch_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .halt(halt), .halted(halted),
        .cnt_clr(cnt_clr), .contention_cnt(contention_cnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // The real memory, driven by the DUT.
    logic [DW-1:0] mem [8] = '{32'h0BAD_F00D, 32'h1111_2222, 32'h3333_4444,
                               32'hDEAD_BEEF, 32'h7777_8888, 32'h5555_AAAA,
                               32'h9999_0000, 32'hCAFE_BABE};
    always @(posedge clk) begin
        mem_q <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Model: what memory should hold, who was served last, what is in flight.
    logic [DW-1:0] sm [8] = '{32'h0BAD_F00D, 32'h1111_2222, 32'h3333_4444,
                              32'hDEAD_BEEF, 32'h7777_8888, 32'h5555_AAAA,
                              32'h9999_0000, 32'hCAFE_BABE};
    logic          m_dbg_last;
    int            m_ret;
    logic [DW-1:0] m_ret_data;
    logic [DW-1:0] m_frd;
    logic [DW-1:0] m_drd;
    logic          m_halted;
    int            m_cnt;
    logic          e_fg, e_dg, e_fe;

    always_comb begin
        e_fe = fetch_req && !halt;
        e_fg = 1'b0;
        e_dg = 1'b0;
        if (rst_n) begin
            if (e_fe && dbg_req) begin
                e_fg = m_dbg_last;
                e_dg = !m_dbg_last;
            end else begin
                e_fg = e_fe;
                e_dg = dbg_req;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dbg_last <= 1'b1;
            m_ret      <= 0;
            m_ret_data <= '0;
            m_frd      <= '0;
            m_drd      <= '0;
            m_halted   <= 1'b0;
            m_cnt      <= 0;
        end else begin
            if (m_ret == 1) m_frd <= m_ret_data;
            if (m_ret == 2) m_drd <= m_ret_data;
            m_ret <= 0;
            if (e_fg) begin
                m_ret      <= 1;
                m_ret_data <= sm[fetch_addr];
                m_dbg_last <= 1'b0;
            end else if (e_dg) begin
                m_dbg_last <= 1'b1;
                if (dbg_we) begin
                    sm[dbg_addr] <= dbg_wdata;
                end else begin
                    m_ret      <= 2;
                    m_ret_data <= sm[dbg_addr];
                end
            end
            if (cnt_clr) m_cnt <= 0;
            else if (e_fe && dbg_req && m_cnt < CMAX) m_cnt <= m_cnt + 1;
            m_halted <= halt && !e_fg;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("fetch_gnt", 32'(fetch_gnt), 32'(e_fg));
        chk("dbg_gnt", 32'(dbg_gnt), 32'(e_dg));
        chk("mem_addr", 32'(mem_addr), 32'(e_dg ? dbg_addr : fetch_addr));
        chk("mem_we", 32'(mem_we), 32'(e_dg && dbg_we));
        chk("mem_wdata", mem_wdata, dbg_wdata);
        chk("fetch_rvalid", 32'(fetch_rvalid), 32'(m_ret == 1));
        chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_ret == 2));
        chk("fetch_rdata", fetch_rdata, (m_ret == 1) ? m_ret_data : m_frd);
        chk("dbg_rdata", dbg_rdata, (m_ret == 2) ? m_ret_data : m_drd);
        chk("halted", 32'(halted), 32'(m_halted));
        chk("contention_cnt", 32'(contention_cnt), 32'(m_cnt));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        fetch_req = 1'b1;
        fetch_addr = 3'd3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_fetch_gnt", 32'(fetch_gnt), 32'd1);
        chk("rel_cnt", 32'(contention_cnt), 32'd0);
        cyc();
        @(negedge clk);
        chk("rel_rvalid", 32'(fetch_rvalid), 32'd1);
        chk("rel_rdata", fetch_rdata, 32'hDEAD_BEEF);

        // Round-robin tie: a dbg write first makes fetch win the tie.
        cyc();
        fetch_req = 1'b0;
        dbg_req = 1'b1;
        dbg_we = 1'b1;
        dbg_addr = 3'd6;
        dbg_wdata = 32'h6666_0006;
        cnt_clr = 1'b1;
        @(negedge clk);
        chk("pre_dbg_gnt", 32'(dbg_gnt), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            fetch_req = 1'b1;
            fetch_addr = 3'd0;
            dbg_we = 1'b0;
            dbg_addr = 3'd5;
            cnt_clr = 1'b0;
            @(negedge clk);
            chk("tie_fetch_gnt", 32'(fetch_gnt), 32'(k % 2));
            chk("tie_dbg_gnt", 32'(dbg_gnt), 32'(1 - k % 2));
            chk("tie_dbg_rvalid", 32'(dbg_rvalid), 32'(k == 3));
        end
        cyc();
        fetch_req = 1'b0;
        dbg_req = 1'b0;
        @(negedge clk);
        chk("tie_dbg_rvalid5", 32'(dbg_rvalid), 32'd1);
        chk("tie_dbg_rdata", dbg_rdata, 32'h5555_AAAA);
        chk("tie_cnt", 32'(contention_cnt), 32'd4);

        // Halt with a fetch read in flight.
        cyc();
        fetch_req = 1'b1;
        fetch_addr = 3'd1;
        @(negedge clk);
        chk("h_gnt_n", 32'(fetch_gnt), 32'd1);
        cyc();
        halt = 1'b1;
        @(negedge clk);
        chk("h_rvalid", 32'(fetch_rvalid), 32'd1);
        chk("h_rdata", fetch_rdata, 32'h1111_2222);
        chk("h_gnt_n1", 32'(fetch_gnt), 32'd0);
        chk("h_halted_n1", 32'(halted), 32'd0);
        cyc();
        @(negedge clk);
        chk("h_halted_n2", 32'(halted), 32'd1);
        chk("h_gnt_n2", 32'(fetch_gnt), 32'd0);
        cyc();
        dbg_req = 1'b1;
        dbg_we = 1'b1;
        dbg_addr = 3'd2;
        dbg_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("h_dbg_gnt", 32'(dbg_gnt), 32'd1);
        chk("h_mem_we", 32'(mem_we), 32'd1);
        chk("h_mem_addr", 32'(mem_addr), 32'd2);
        chk("h_mem_wdata", mem_wdata, 32'h1234_5678);
        cyc();
        dbg_req = 1'b0;
        halt = 1'b0;
        @(negedge clk);
        chk("h_no_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("h_halted_held", 32'(halted), 32'd1);
        cyc();
        @(negedge clk);
        chk("h_halted_fall", 32'(halted), 32'd0);

        // Saturation and clear-over-increment.
        cyc();
        dbg_req = 1'b1;
        dbg_we = 1'b0;
        repeat (300) cyc();
        @(negedge clk);
        chk("sat_cnt", 32'(contention_cnt), 32'd255);
        cyc();
        cnt_clr = 1'b1;
        @(negedge clk);
        chk("sat_hold", 32'(contention_cnt), 32'd255);
        cyc();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_cnt", 32'(contention_cnt), 32'd0);
        cyc();
        @(negedge clk);
        chk("clr_inc", 32'(contention_cnt), 32'd1);

        // Async reset between grant and return edges.
        cyc();
        dbg_req = 1'b0;
        fetch_addr = 3'd3;
        @(negedge clk);
        chk("ar_gnt", 32'(fetch_gnt), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        dbg_req = 1'b1;
        dbg_we = 1'b1;
        #1;
        chk("ar_rvalid", 32'(fetch_rvalid), 32'd0);
        chk("ar_rdata", fetch_rdata, 32'd0);
        chk("ar_mem_we", 32'(mem_we), 32'd0);
        chk("ar_dbg_gnt", 32'(dbg_gnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dbg_we = 1'b0;
        @(negedge clk);
        chk("ar_first_fetch", 32'(fetch_gnt), 32'd1);
        chk("ar_first_dbg", 32'(dbg_gnt), 32'd0);
        cyc();
        @(negedge clk);
        chk("ar_second_dbg", 32'(dbg_gnt), 32'd1);

        // Randomized traffic, including occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            fetch_req = ($urandom_range(9) < 7);
            fetch_addr = AW'($urandom_range(7));
            dbg_req = ($urandom_range(1) == 1);
            dbg_we = ($urandom_range(1) == 1);
            dbg_addr = AW'($urandom_range(7));
            dbg_wdata = $urandom;
            halt = ($urandom_range(4) == 0);
            cnt_clr = ($urandom_range(19) == 0);
            rst_n = ($urandom_range(299) != 0);
        end
        cyc();
        rst_n = 1'b1;
        fetch_req = 1'b0;
        dbg_req = 1'b0;
        halt = 1'b0;
        cnt_clr = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the CPU's single-port synchronous instruction memory between two requesters.
- Requester 1 is the core's fetch port, which only reads.
- Requester 2 is a debug/loader port, which reads and writes and is used to load programs and inspect memory.
- Sits between the core and the memory. Provides round-robin arbitration, a halt mechanism that freezes fetch while the loader works, and a saturating contention counter.

Parameters:
- ADDR_WIDTH, 3, memory address width in bits.
- DATA_WIDTH, 32, memory word width in bits.
- CNT_WIDTH, 8, width of the contention counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  core requests a read at fetch_addr; held until fetch_gnt.
- fetch_addr  in  ADDR_WIDTH  fetch read address.
- fetch_gnt  out  1  fetch request accepted this cycle (combinational).
- fetch_rvalid  out  1  fetch_rdata valid; registered one-cycle pulse.
- fetch_rdata  out  DATA_WIDTH  fetch read data.
- dbg_req  in  1  loader request; held until dbg_gnt.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_WIDTH  loader address.
- dbg_wdata  in  DATA_WIDTH  loader write data.
- dbg_gnt  out  1  loader request accepted this cycle (combinational).
- dbg_rvalid  out  1  dbg_rdata valid; one-cycle pulse, reads only.
- dbg_rdata  out  DATA_WIDTH  loader read data.
- halt  in  1  1 = block new fetch grants.
- halted  out  1  registered; 1 when halt=1 and no fetch read is outstanding.
- cnt_clr  in  1  synchronous clear of contention counter.
- contention_cnt  out  CNT_WIDTH  cycles in which a requester was denied; saturates.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_q  in  DATA_WIDTH  memory read data; valid one cycle after address presented.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Cleared to 0: fetch_rvalid, dbg_rvalid, fetch_rdata, dbg_rdata, halted, contention_cnt, pending-read owner.
  - last_winner set to DBG.
  - While rst_n=0, both gnt=0 and mem_we=0, regardless of requests.
- Eligibility:
  - fetch_elig = fetch_req & ~halt.
  - dbg_elig = dbg_req.
- Grant (combinational, at most one per cycle):
  - Only one eligible: that requester is granted.
  - Both eligible: grant the requester that is not last_winner.
  - last_winner updates to the granted requester on each grant.
  - Reset value DBG means fetch wins the first tie.
  - Bound: no requester waits more than one grant.
- Memory drive:
  - Fetch granted: mem_addr=fetch_addr, mem_we=0.
  - Dbg granted: mem_addr=dbg_addr, mem_we=dbg_we, mem_wdata=dbg_wdata.
  - No grant: mem_addr=fetch_addr, mem_we=0, mem_wdata=dbg_wdata.
- Read return:
  - A read granted in cycle N asserts the owner's rvalid for exactly cycle N+1.
  - In N+1 the owner's rdata = mem_q.
  - rdata holds the last returned value at all other times.
  - Dbg writes produce no rvalid.
- Throughput: back-to-back grants allowed every cycle, e.g. fetch in N, dbg in N+1. Returns are pipelined with no bubbles.
- Halt:
  - Assertion blocks new fetch grants in the same cycle.
  - A fetch read already granted still returns its rvalid.
  - halted rises on the first clock edge where halt=1 and no fetch read is pending. With halt=1 and no outstanding read, halted=1 one cycle after halt rises.
  - halted falls on the clock edge after halt deasserts.
  - Dbg traffic is unaffected by halt.
- Contention counter:
  - Increments by 1 each cycle both requesters are eligible (exactly one is then denied).
  - A fetch_req masked by halt does not count.
  - Saturates at 2^CNT_WIDTH-1.
  - cnt_clr has priority over increment: the next value is 0.
- Simultaneous events: dbg write and fetch read to the same address in consecutive cycles are not reordered. Memory sees grant order exactly.
- Reset mid-operation: an outstanding read's rvalid is dropped. After release, arbitration restarts with fetch priority.

Test Plan:
- Reset release:
  - Stimulus: fetch_req=1 at addr 3, mem_q=0xDEADBEEF in the following cycle.
  - Required: fetch_gnt=1 in the first active cycle, fetch_rvalid=1 the next cycle, fetch_rdata=0xDEADBEEF, contention_cnt=0.
- Tie round-robin:
  - Stimulus: fetch_req and dbg_req (read, addr 5) held high for 4 cycles.
  - Required: grants alternate F,D,F,D; dbg_rvalid pulses in cycles 3 and 5; contention_cnt=4.
- Halt with outstanding read:
  - Stimulus: fetch granted in cycle N, halt=1 in N+1, fetch_req held.
  - Required: fetch_rvalid=1 in N+1, no further fetch_gnt, halted=1 from N+2.
  - Then dbg write 0x12345678 to addr 2: dbg_gnt same cycle, mem_we=1, no dbg_rvalid.
- Counter saturation/clear:
  - Stimulus: CNT_WIDTH=8, both requesting for 300 cycles.
  - Required: contention_cnt=255 held; cnt_clr with contention in the same cycle gives 0 next cycle.
- Async reset mid-read:
  - Stimulus: drop rst_n between the grant edge and the return edge.
  - Required: rvalid=0 immediately, rdata=0, mem_we=0.
  - After release with both requesting, the first grant goes to fetch.
